// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: widths and the
// data-memory access FSM state encoding.
package mem_stage_pkg;

    localparam int BIT_W_DEF = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A stall turns the slot into a bubble by dropping
// the write enable; rd and data simply hold.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int BIT_W = BIT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic                 regwr_i,
    input  logic [BIT_W-1:0]     data_i,
    output logic [REG_IDX_W-1:0] wb_rd_o,
    output logic                 wb_regwr_o,
    output logic [BIT_W-1:0]     wb_data_o
);

    logic [REG_IDX_W-1:0] rd_q;
    logic                 regwr_q;
    logic [BIT_W-1:0]     data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            regwr_q <= 1'b0;
            data_q  <= '0;
        end else if (stall_i) begin
            regwr_q <= 1'b0;
        end else begin
            rd_q    <= rd_i;
            regwr_q <= regwr_i;
            data_q  <= data_i;
        end
    end

    assign wb_rd_o    = rd_q;
    assign wb_regwr_o = regwr_q;
    assign wb_data_o  = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory req/ready FSM,
// forwarding outputs and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BIT_W    = BIT_W_DEF,
    parameter int ADDR_LSB = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_W-1:0]     ex_alu_result,
    input  logic [BIT_W-1:0]     ex_mem_wdata,
    input  logic [BIT_W-1:0]     ex_pc_plus_4,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memrd,
    input  logic                 ex_memwr,
    input  logic                 ex_mem2reg,
    input  logic                 ex_regwr,
    input  logic                 ex_jump,
    output logic                 dmem_req,
    output logic                 dmem_wr,
    output logic [BIT_W-1:0]     dmem_addr,
    output logic [BIT_W-1:0]     dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [BIT_W-1:0]     dmem_rdata,
    output logic                 stall_out,
    output logic [REG_IDX_W-1:0] fwd_rd,
    output logic                 fwd_regwr,
    output logic [BIT_W-1:0]     fwd_data,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_regwr,
    output logic [BIT_W-1:0]     wb_data,
    output logic                 misalign_err,
    output logic [31:0]          stall_cycles
);

    logic [BIT_W-1:0]     alu_result_q;
    logic [BIT_W-1:0]     mem_wdata_q;
    logic [BIT_W-1:0]     pc_plus_4_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 memrd_q;
    logic                 memwr_q;
    logic                 mem2reg_q;
    logic                 regwr_q;
    logic                 jump_q;

    mem_state_e           state_q;
    logic                 misalign_q;
    logic [31:0]          stall_cycles_q;

    logic                 mem_op;
    logic [BIT_W-1:0]     wb_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
            mem_wdata_q  <= '0;
            pc_plus_4_q  <= '0;
            rd_q         <= '0;
            memrd_q      <= 1'b0;
            memwr_q      <= 1'b0;
            mem2reg_q    <= 1'b0;
            regwr_q      <= 1'b0;
            jump_q       <= 1'b0;
        end else if (!stall_out) begin
            alu_result_q <= ex_alu_result;
            mem_wdata_q  <= ex_mem_wdata;
            pc_plus_4_q  <= ex_pc_plus_4;
            rd_q         <= ex_rd;
            memrd_q      <= ex_memrd;
            memwr_q      <= ex_memwr;
            mem2reg_q    <= ex_mem2reg;
            regwr_q      <= ex_regwr;
            jump_q       <= ex_jump;
        end
    end

    assign mem_op    = memrd_q | memwr_q;
    assign stall_out = mem_op & ~dmem_ready;

    // Holding the EX/MEM register during a stall keeps the request stable.
    assign dmem_req   = mem_op;
    assign dmem_wr    = memwr_q;
    assign dmem_addr  = {alu_result_q[BIT_W-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign dmem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mem_op && !dmem_ready) state_q <= ST_WAIT;
                ST_WAIT: if (dmem_ready)            state_q <= ST_IDLE;
                default:                            state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            if (dmem_req && (alu_result_q[ADDR_LSB-1:0] != '0))
                misalign_q <= 1'b1;
            if (stall_out)
                stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign misalign_err = misalign_q;
    assign stall_cycles = stall_cycles_q;

    // Loads must not forward from EX/MEM; the hazard unit resolves load-use.
    assign fwd_rd    = rd_q;
    assign fwd_regwr = regwr_q & ~memrd_q;
    assign fwd_data  = jump_q ? pc_plus_4_q : alu_result_q;

    // NOTE: every branch assigns wb_data_d, so no latch is inferred.
    always_comb begin
        if (jump_q)
            wb_data_d = pc_plus_4_q;
        else if (mem2reg_q)
            wb_data_d = dmem_rdata;
        else
            wb_data_d = alu_result_q;
    end

    mem_wb_reg #(
        .BIT_W(BIT_W)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_out),
        .rd_i      (rd_q),
        .regwr_i   (regwr_q),
        .data_i    (wb_data_d),
        .wb_rd_o   (wb_rd),
        .wb_regwr_o(wb_regwr),
        .wb_data_o (wb_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load/store with and without waits,
// jal forwarding, misalignment and reset during a wait.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_alu_result, ex_mem_wdata, ex_pc_plus_4;
    logic [4:0]  ex_rd;
    logic        ex_memrd, ex_memwr, ex_mem2reg, ex_regwr, ex_jump;
    logic        dmem_req, dmem_wr, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out;
    logic [4:0]  fwd_rd, wb_rd;
    logic        fwd_regwr, wb_regwr, misalign_err;
    logic [31:0] fwd_data, wb_data, stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_alu_result(ex_alu_result),
        .ex_mem_wdata (ex_mem_wdata),
        .ex_pc_plus_4 (ex_pc_plus_4),
        .ex_rd        (ex_rd),
        .ex_memrd     (ex_memrd),
        .ex_memwr     (ex_memwr),
        .ex_mem2reg   (ex_mem2reg),
        .ex_regwr     (ex_regwr),
        .ex_jump      (ex_jump),
        .dmem_req     (dmem_req),
        .dmem_wr      (dmem_wr),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .stall_out    (stall_out),
        .fwd_rd       (fwd_rd),
        .fwd_regwr    (fwd_regwr),
        .fwd_data     (fwd_data),
        .wb_rd        (wb_rd),
        .wb_regwr     (wb_regwr),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        ex_alu_result = '0; ex_mem_wdata = '0; ex_pc_plus_4 = '0; ex_rd = '0;
        ex_memrd = 0; ex_memwr = 0; ex_mem2reg = 0; ex_regwr = 0; ex_jump = 0;
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] wdata,
                            input logic [31:0] pc4, input logic [4:0] rd,
                            input logic rd_en, input logic wr_en, input logic m2r,
                            input logic rw, input logic jmp);
        ex_alu_result = alu; ex_mem_wdata = wdata; ex_pc_plus_4 = pc4; ex_rd = rd;
        ex_memrd = rd_en; ex_memwr = wr_en; ex_mem2reg = m2r; ex_regwr = rw; ex_jump = jmp;
    endtask

    initial begin
        drive_nop();
        dmem_ready = 0;
        dmem_rdata = '0;
        rst = 1;
        step();
        step();
        check("rst_wb_regwr", {31'd0, wb_regwr}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 0;

        // ALU op
        drive_op(32'h0000_1234, 0, 0, 5'd5, 0, 0, 0, 1, 0);
        step();
        check("alu_fwd_data", fwd_data, 32'h1234);
        check("alu_fwd_regwr", {31'd0, fwd_regwr}, 32'd1);
        check("alu_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        check("alu_dmem_req", {31'd0, dmem_req}, 32'd0);
        drive_nop();
        step();
        check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
        check("alu_wb_regwr", {31'd0, wb_regwr}, 32'd1);
        check("alu_wb_data", wb_data, 32'h1234);

        // Load, zero-wait
        drive_op(32'h100, 0, 0, 5'd7, 1, 0, 1, 1, 0);
        dmem_ready = 1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        check("ld0_req", {31'd0, dmem_req}, 32'd1);
        check("ld0_wr", {31'd0, dmem_wr}, 32'd0);
        check("ld0_addr", dmem_addr, 32'h100);
        check("ld0_stall", {31'd0, stall_out}, 32'd0);
        check("ld0_fwd_regwr", {31'd0, fwd_regwr}, 32'd0);
        drive_nop();
        step();
        check("ld0_wb_data", wb_data, 32'hDEAD_BEEF);
        check("ld0_wb_rd", {27'd0, wb_rd}, 32'd7);
        check("ld0_wb_regwr", {31'd0, wb_regwr}, 32'd1);
        check("ld0_stall_cycles", stall_cycles, 32'd0);
        dmem_ready = 0;

        // Store, 3 wait cycles
        drive_op(32'h200, 32'hA5A5_A5A5, 0, 5'd0, 0, 1, 0, 0, 0);
        step();
        drive_nop();
        for (int i = 0; i < 3; i++) begin
            check("st_stall", {31'd0, stall_out}, 32'd1);
            check("st_req", {31'd0, dmem_req}, 32'd1);
            check("st_wr", {31'd0, dmem_wr}, 32'd1);
            check("st_addr", dmem_addr, 32'h200);
            check("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
            step();
            check("st_bubble", {31'd0, wb_regwr}, 32'd0);
        end
        check("st_stall_cycles", stall_cycles, 32'd3);
        dmem_ready = 1;
        #1;
        check("st_done_stall", {31'd0, stall_out}, 32'd0);
        check("st_done_req", {31'd0, dmem_req}, 32'd1);
        check("st_done_addr", dmem_addr, 32'h200);
        check("st_done_wdata", dmem_wdata, 32'hA5A5_A5A5);
        step();
        check("st_after_req", {31'd0, dmem_req}, 32'd0);
        check("st_after_cycles", stall_cycles, 32'd3);
        dmem_ready = 0;

        // Load, 1 wait cycle: the stalled slot must be a bubble
        drive_op(32'h180, 0, 0, 5'd3, 1, 0, 1, 1, 0);
        step();
        drive_nop();
        check("ld1_stall", {31'd0, stall_out}, 32'd1);
        step();
        check("ld1_bubble", {31'd0, wb_regwr}, 32'd0);
        check("ld1_stall_cycles", stall_cycles, 32'd4);
        dmem_ready = 1;
        dmem_rdata = 32'h0BAD_F00D;
        step();
        check("ld1_wb_regwr", {31'd0, wb_regwr}, 32'd1);
        check("ld1_wb_rd", {27'd0, wb_rd}, 32'd3);
        check("ld1_wb_data", wb_data, 32'h0BAD_F00D);
        dmem_ready = 0;

        // jal
        drive_op(32'h80, 0, 32'h44, 5'd1, 0, 0, 0, 1, 1);
        step();
        check("jal_fwd_data", fwd_data, 32'h44);
        check("jal_req", {31'd0, dmem_req}, 32'd0);
        drive_nop();
        step();
        check("jal_wb_data", wb_data, 32'h44);
        check("jal_wb_rd", {27'd0, wb_rd}, 32'd1);

        // Both memrd and memwr behave as a store
        drive_op(32'h40, 32'h1111_2222, 0, 5'd0, 1, 1, 0, 0, 0);
        dmem_ready = 1;
        step();
        check("rdwr_is_store", {31'd0, dmem_wr}, 32'd1);
        check("rdwr_misalign", {31'd0, misalign_err}, 32'd0);

        // Misaligned load
        drive_op(32'h103, 0, 0, 5'd2, 1, 0, 1, 1, 0);
        dmem_rdata = 32'h55;
        step();
        check("mis_addr", dmem_addr, 32'h100);
        drive_nop();
        step();
        check("mis_err_set", {31'd0, misalign_err}, 32'd1);
        check("mis_wb_data", wb_data, 32'h55);
        dmem_ready = 0;
        drive_op(32'h8, 0, 0, 5'd4, 0, 0, 0, 1, 0);
        step();
        drive_nop();
        step();
        check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);

        // Reset while waiting
        drive_op(32'h300, 32'h77, 0, 5'd0, 0, 1, 0, 0, 0);
        step();
        drive_nop();
        check("rw_stall", {31'd0, stall_out}, 32'd1);
        step();
        check("rw_cycles_pre", stall_cycles, 32'd5);
        rst = 1;
        step();
        check("rw_req", {31'd0, dmem_req}, 32'd0);
        check("rw_stall_out", {31'd0, stall_out}, 32'd0);
        check("rw_wb_regwr", {31'd0, wb_regwr}, 32'd0);
        check("rw_cycles", stall_cycles, 32'd0);
        check("rw_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 0;

        // Pipeline works again after reset
        drive_op(32'h9, 0, 0, 5'd6, 0, 0, 0, 1, 0);
        step();
        drive_nop();
        step();
        check("post_wb_data", wb_data, 32'h9);
        check("post_wb_rd", {27'd0, wb_rd}, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Contains the EX/MEM pipeline register and the data-memory access FSM with a req/ready handshake.
- Produces the MEM/WB register contents: write-back data, rd and regwr.
- Drives a stall to the hazard unit while a data access is outstanding.
- Exports EX/MEM-stage forwarding values.

Parameters:
- BIT_W, 32, datapath and address width.
- ADDR_LSB, 2, byte-offset bits ignored for word access; a nonzero offset flags misalignment.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_alu_result  in  BIT_W  ALU result (memory address, or non-memory result)
- ex_mem_wdata  in  BIT_W  store data
- ex_pc_plus_4  in  BIT_W  link value for jal/jalr
- ex_rd  in  5  destination register
- ex_memrd, ex_memwr, ex_mem2reg, ex_regwr, ex_jump  in  1 each  control from the execute stage
- dmem_req  out  1  data-memory request
- dmem_wr  out  1  1 = store, 0 = load
- dmem_addr  out  BIT_W  word address, low ADDR_LSB bits forced 0
- dmem_wdata  out  BIT_W  store data
- dmem_ready  in  1  memory completes the access this cycle
- dmem_rdata  in  BIT_W  load data, valid when dmem_ready=1
- stall_out  out  1  freeze upstream stages and the PC
- fwd_rd  out  5  EX/MEM rd
- fwd_regwr  out  1  EX/MEM regwr, gated 0 for loads
- fwd_data  out  BIT_W  EX/MEM value: pc_plus_4 if jump, else alu_result
- wb_rd  out  5  MEM/WB rd
- wb_regwr  out  1  MEM/WB write enable
- wb_data  out  BIT_W  MEM/WB write-back data
- misalign_err  out  1  sticky misaligned-access flag
- stall_cycles  out  32  count of cycles with stall_out=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - All EX/MEM and MEM/WB registers, misalign_err and stall_cycles go to 0.
  - FSM goes to IDLE.
  - dmem_req=0 from the following cycle, even if an access is mid-flight. The memory must tolerate an abandoned request.
- EX/MEM register: loads the ex_* inputs at each edge where stall_out=0. It holds while stall_out=1.
- Memory op: mem_op = q_memrd | q_memwr (q_ denotes the EX/MEM register).
- FSM states are IDLE and WAIT.
  - IDLE, no mem_op: dmem_req=0, stall_out=0.
  - IDLE, mem_op, dmem_ready=1: zero-wait completion. stall_out=0; stay IDLE.
  - IDLE, mem_op, dmem_ready=0: stall_out=1; go to WAIT.
  - WAIT, dmem_ready=0: stall_out=1; stay in WAIT.
  - WAIT, dmem_ready=1: stall_out=0; go to IDLE.
  - stall_out = mem_op & ~dmem_ready in both states. dmem_req = mem_op.
- While dmem_req=1: dmem_wr, dmem_addr and dmem_wdata come straight from the EX/MEM register. They stay stable until dmem_ready.
- Both memrd and memwr set: treated as a store.
- MEM/WB register, updated every edge:
  - If stall_out=1: insert a bubble (wb_regwr=0; wb_rd and wb_data don't-care, hold).
  - Otherwise: wb_rd=q_rd and wb_regwr=q_regwr.
  - wb_data priority: q_jump → q_pc_plus_4; else q_mem2reg → dmem_rdata; else q_alu_result.
- Latency:
  - Non-memory op: wb_* valid 1 cycle after capture into EX/MEM.
  - Load/store: wb_* valid 1+N cycles after capture, where N = wait cycles before dmem_ready.
- Forwarding: fwd_regwr = q_regwr & ~q_memrd. The hazard unit handles load-use.
- misalign_err: set when mem_op=1 and q_alu_result[ADDR_LSB-1:0]≠0 while dmem_req=1. Stays set until reset. The access still proceeds, word-aligned.
- stall_cycles: increments each cycle with stall_out=1 and wraps at 2^32.

Decomposition:
- Shared pipeline package: holds the BIT_W default, the register-index width (5), and the FSM state encoding constants (IDLE=0, WAIT=1).
- Sub-module: one, mem_wb_reg (MEM/WB register with bubble insertion). Everything else stays in mem_stage.

Test Plan:
- ALU op: alu_result=0x0000_1234, rd=5, regwr=1 → next cycle wb_rd=5, wb_regwr=1, wb_data=0x1234; dmem_req stays 0.
- Load, zero-wait: addr=0x100, dmem_ready=1 same cycle with rdata=0xDEADBEEF, mem2reg=1, rd=7 → stall_out never 1; next cycle wb_data=0xDEADBEEF, wb_rd=7; fwd_regwr=0 during EX/MEM.
- Store, 3 wait cycles: addr=0x200, wdata=0xA5A5A5A5, ready after 3 cycles → dmem_req/wr/addr/wdata stable for 4 cycles; stall_out=1 for 3 cycles; wb_regwr=0 bubbles; stall_cycles=3.
- jal: jump=1, pc_plus_4=0x0000_0044, alu_result=0x80 → wb_data=0x44; fwd_data=0x44.
- Misaligned load: addr=0x103 → dmem_addr=0x100 and misalign_err=1, staying set through later aligned ops until rst.
- Reset in WAIT: assert rst mid-stall → next cycle dmem_req=0, stall_out=0, wb_regwr=0, stall_cycles=0, FSM IDLE.
